// File: rtl/noisy_sample_source.sv
// Synthesizable waveform player: streams a stored sample buffer with saturating
// LFSR noise added, under a valid/ready handshake with programmable spacing.
module noisy_sample_source #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 172,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned NOISE_BITS = 8,
   parameter logic [31:0] LFSR_SEED  = 32'h1234_5678
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] len,
   input  logic              loop_en,
   input  logic              noise_en,
   input  logic [7:0]        rate_div,
   output logic [DATA_W-1:0] noisy_data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CALC,
      S_PRESENT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [31:0]   SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   q;
   logic [ADDR_W-1:0]   rd_addr, len_lat, len_clamped;
   logic                loop_lat;
   logic [7:0]          rate_lat, gap_cnt;
   logic [31:0]         lfsr;
   logic                start_acc, hs, last, stop_act, done_set;
   logic [DATA_W-1:0]   noise, sat_sum;
   logic [DATA_W:0]     sum;

   // Read-before-write ordering gives old data on a same-address collision
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < DEPTH_W))
         mem[wr_addr] <= wr_data;
      q <= mem[rd_addr];
   end

   assign busy        = (state != S_IDLE) && (state != S_DONE);
   assign stop_act    = stop && busy;
   assign len_clamped = ({1'b0, len} > DEPTH_W) ? DEPTH_W[ADDR_W-1:0] : len;
   assign last        = (rd_addr == len_lat - ADDR_W'(1));
   assign noise       = noise_en ? {{(DATA_W-NOISE_BITS){lfsr[NOISE_BITS-1]}}, lfsr[NOISE_BITS-1:0]} : '0;
   assign sum         = {q[DATA_W-1], q} + {noise[DATA_W-1], noise};
   assign sat_sum     = (sum[DATA_W] != sum[DATA_W-1]) ?
                        {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      done_set  = 1'b0;
      hs        = (state == S_PRESENT) && data_valid && data_ready && !stop;
      case (state)
         S_IDLE, S_DONE: begin
            if (start && !stop) begin
               start_acc = 1'b1;
               if (len == '0) begin
                  state_nxt = S_DONE;
                  done_set  = 1'b1;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         end
         S_FETCH: state_nxt = S_CALC;
         S_CALC:  state_nxt = S_PRESENT;
         S_PRESENT: begin
            if (hs) begin
               if (last && !loop_lat) begin
                  state_nxt = S_DONE;
                  done_set  = 1'b1;
               end else if (rate_lat != 8'd0) begin
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == 8'd0) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (stop_act) begin
         state_nxt = S_IDLE;
         done_set  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr    <= '0;
         len_lat    <= '0;
         loop_lat   <= 1'b0;
         rate_lat   <= '0;
         gap_cnt    <= '0;
         lfsr       <= SEED_EFF;
         noisy_data <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= done_set;
         if (stop_act) begin
            data_valid <= 1'b0;
         end else begin
            if (start_acc) begin
               rd_addr  <= '0;
               len_lat  <= len_clamped;
               loop_lat <= loop_en;
               rate_lat <= rate_div;
            end
            if (state == S_CALC) begin
               noisy_data <= sat_sum;
               data_valid <= 1'b1;
            end
            if (hs) begin
               data_valid <= 1'b0;
               lfsr       <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
               gap_cnt    <= rate_lat - 8'd1;
               if (!last)         rd_addr <= rd_addr + ADDR_W'(1);
               else if (loop_lat) rd_addr <= '0;
            end
            if ((state == S_GAP) && (gap_cnt != 8'd0))
               gap_cnt <= gap_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_noisy_sample_source.sv
// Randomized self-checking bench for noisy_sample_source against a
// sequence-level model of buffer playback, LFSR noise and saturation.
module tb_noisy_sample_source;

   localparam logic [31:0] SEED = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        start = 1'b0, stop = 1'b0;
   logic [7:0]  len = '0;
   logic        loop_en = 1'b0, noise_en = 1'b0;
   logic [7:0]  rate_div = '0;
   logic        data_ready = 1'b1;

   logic [31:0] nd, p_nd, n_nd;
   logic        dv, bz, dn, p_dv, p_bz, p_dn, n_dv, n_bz, n_dn;

   noisy_sample_source #(.LFSR_SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .len(len), .loop_en(loop_en), .noise_en(noise_en),
      .rate_div(rate_div), .noisy_data(nd), .data_valid(dv), .data_ready(data_ready),
      .busy(bz), .done(dn));

   noisy_sample_source #(.LFSR_SEED(32'h0000_007F)) dut_pos (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .len(len), .loop_en(loop_en), .noise_en(noise_en),
      .rate_div(rate_div), .noisy_data(p_nd), .data_valid(p_dv), .data_ready(data_ready),
      .busy(p_bz), .done(p_dn));

   noisy_sample_source #(.LFSR_SEED(32'h0000_0080)) dut_neg (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .len(len), .loop_en(loop_en), .noise_en(noise_en),
      .rate_div(rate_div), .noisy_data(n_nd), .data_valid(n_dv), .data_ready(data_ready),
      .busy(n_bz), .done(n_dn));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [31:0] bufm [256];
   logic [31:0] lfsr_m = SEED;

   logic [31:0] obs_q[$];
   int          stamp_q[$];
   int          done_cnt;
   bit          saw_busy, timed_out, stall_bad, stop_seen, post_valid, post_busy;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sat_model(input logic [31:0] d, input logic [31:0] l, input bit ne);
      longint s;
      s = longint'($signed(d));
      if (ne) s = s + longint'($signed(l[7:0]));
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   function automatic logic [31:0] model_next(input int addr, input bit ne);
      logic [31:0] r;
      r = sat_model(bufm[addr], lfsr_m, ne);
      lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
      return r;
   endfunction

   task automatic write_word(input int a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a[7:0]; wr_data = d;
      if (a < 172) bufm[a] = d;
      tick;
      wr_en = 1'b0;
   endtask

   task automatic pulse_reset;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      lfsr_m = SEED;
      tick;
   endtask

   // Pulses start, then records every accepted sample and its cycle stamp
   task automatic collect(input int max_cyc, input bit rnd_ready, input int stall_at,
                          input int stall_len, input int stop_at, input bit scramble);
      int          stall_left = 0;
      bit          stalled = 1'b0;
      logic [31:0] stall_val = '0;
      int          idle = 0;
      int          cyc;
      obs_q.delete(); stamp_q.delete();
      done_cnt = 0; saw_busy = 0; stall_bad = 0; stop_seen = 0; post_valid = 0; post_busy = 0;
      start = 1'b1;
      tick;
      start = 1'b0;
      if (scramble) begin
         len = $urandom; rate_div = $urandom; loop_en = $urandom;
      end
      for (cyc = 0; cyc < max_cyc; cyc++) begin
         if (stop_at >= 0 && !stop_seen && dv && obs_q.size() == stop_at) begin
            stop = 1'b1; data_ready = $urandom_range(0, 1); stop_seen = 1'b1;
            if (dn) done_cnt++;
            tick;
            stop = 1'b0;
            post_valid = dv; post_busy = bz;
            continue;
         end
         if (stall_left > 0) begin
            data_ready = 1'b0;
            if (!dv || nd !== stall_val) stall_bad = 1'b1;
            stall_left--;
         end else if (stall_at >= 0 && !stalled && dv && obs_q.size() == stall_at) begin
            stalled = 1'b1; stall_left = stall_len - 1; stall_val = nd; data_ready = 1'b0;
         end else begin
            data_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (dv && data_ready) begin
            obs_q.push_back(nd);
            stamp_q.push_back(cyc);
         end
         if (dn) done_cnt++;
         if (bz) saw_busy = 1'b1;
         else    idle++;
         if (idle >= 3) break;
         tick;
      end
      timed_out = (cyc >= max_cyc);
      data_ready = 1'b1;
   endtask

   task automatic test_reset;
      tick; tick;
      checks++; if (nd !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", nd); end
      checks++; if (dv !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", dv); end
      checks++; if (bz !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bz); end
      checks++; if (dn !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", dn); end
      rst_n = 1'b1;
      tick;
      checks++; if (dv !== 1'b0 || bz !== 1'b0) begin failures++; $display("FAIL post_release: got valid=%b busy=%b want 0 0", dv, bz); end
   endtask

   task automatic test_basic;
      logic [31:0] e;
      for (int i = 0; i < 4; i++) write_word(i, 32'((i + 1) * 16));
      noise_en = 0; len = 4; loop_en = 0; rate_div = 0;
      collect(100, 0, -1, 0, -1, 0);
      checks++; if (obs_q.size() != 4 || timed_out) begin failures++; $display("FAIL basic_count: got %0d want 4 (timeout=%0b)", obs_q.size(), timed_out); end
      for (int i = 0; i < 4; i++) begin
         e = model_next(i, 0);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
         checks++; if (stamp_q[i] - stamp_q[i-1] != 3) begin failures++; $display("FAIL basic_spacing[%0d]: got %0d want 3", i, stamp_q[i] - stamp_q[i-1]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
      checks++; if (bz !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b want 0", bz); end
   endtask

   task automatic test_backpressure;
      logic [31:0] e;
      noise_en = 0; len = 4; loop_en = 0; rate_div = 0;
      collect(100, 0, 1, 5, -1, 0);
      checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL bp_count: got %0d want 4", obs_q.size()); end
      checks++; if (stall_bad) begin failures++; $display("FAIL bp_hold: got unstable output during stall want held valid data"); end
      for (int i = 0; i < 4; i++) begin
         e = model_next(i, 0);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_loop_stop;
      logic [31:0] e;
      for (int i = 0; i < 3; i++) write_word(i, $urandom);
      noise_en = 1; len = 3; loop_en = 1; rate_div = 2;
      collect(200, 0, -1, 0, 4, 1);
      checks++; if (obs_q.size() != 4 || !stop_seen) begin failures++; $display("FAIL loop_count: got %0d stop=%0b want 4 1", obs_q.size(), stop_seen); end
      for (int i = 0; i < 4; i++) begin
         e = model_next(i % 3, 1);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL loop_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
         checks++; if (stamp_q[i] - stamp_q[i-1] != 5) begin failures++; $display("FAIL loop_spacing[%0d]: got %0d want 5", i, stamp_q[i] - stamp_q[i-1]); end
      end
      checks++; if (post_valid !== 1'b0 || post_busy !== 1'b0) begin failures++; $display("FAIL stop_next: got valid=%b busy=%b want 0 0", post_valid, post_busy); end
      checks++; if (done_cnt != 0) begin failures++; $display("FAIL stop_done: got %0d pulses want 0", done_cnt); end
   endtask

   task automatic test_len_zero;
      len = 0; loop_en = 0; rate_div = 0;
      collect(20, 0, -1, 0, -1, 0);
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL len0_count: got %0d want 0", obs_q.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL len0_done: got %0d want 1", done_cnt); end
      checks++; if (saw_busy) begin failures++; $display("FAIL len0_busy: got busy high want never"); end
   endtask

   task automatic test_mid_reset;
      logic [31:0] e;
      noise_en = 0; len = 4; loop_en = 0; rate_div = 0;
      start = 1'b1; tick; start = 1'b0;
      tick; tick; tick;
      rst_n = 1'b0;
      #1;
      checks++; if (dv !== 1'b0 || bz !== 1'b0 || dn !== 1'b0 || nd !== 32'h0) begin
         failures++; $display("FAIL midrst_outputs: got data=%h valid=%b busy=%b done=%b want all 0", nd, dv, bz, dn);
      end
      tick;
      rst_n = 1'b1;
      lfsr_m = SEED;
      tick;
      noise_en = 1;
      collect(200, 1, -1, 0, -1, 0);
      checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL midrst_count: got %0d want 4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         e = model_next(i, 1);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL midrst_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
   endtask

   task automatic test_noise;
      logic [31:0] e;
      pulse_reset;
      write_word(0, 32'h100);
      for (int i = 1; i < 16; i++) write_word(i, $urandom);
      noise_en = 1; len = 16; loop_en = 0; rate_div = $urandom_range(0, 3);
      collect(800, 1, -1, 0, -1, 0);
      checks++; if (obs_q.size() == 0 || obs_q[0] !== 32'h178) begin failures++; $display("FAIL noise_first: got %h want 00000178", obs_q.size() ? obs_q[0] : 32'hx); end
      checks++; if (obs_q.size() != 16) begin failures++; $display("FAIL noise_count: got %0d want 16", obs_q.size()); end
      for (int i = 0; i < 16; i++) begin
         e = model_next(i, 1);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL noise_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL noise_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_len_clamp;
      logic [31:0] e;
      for (int i = 0; i < 172; i++) begin
         case ($urandom_range(0, 3))
            0:       write_word(i, 32'h7FFF_FF00 | 32'($urandom_range(0, 255)));
            1:       write_word(i, 32'h8000_0000 | 32'($urandom_range(0, 255)));
            default: write_word(i, $urandom);
         endcase
      end
      write_word(200, 32'hDEAD_BEEF);
      noise_en = 1; len = 200; loop_en = 0; rate_div = 0;
      collect(3000, 1, -1, 0, -1, 0);
      checks++; if (obs_q.size() != 172) begin failures++; $display("FAIL clamp_count: got %0d want 172", obs_q.size()); end
      for (int i = 0; i < 172; i++) begin
         e = model_next(i, 1);
         if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL clamp_data[%0d]: got %h want %h", i, obs_q[i], e); end
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL clamp_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_sat(input bit neg);
      logic [31:0] e, got;
      int          w;
      pulse_reset;
      write_word(0, neg ? 32'h8000_0010 : 32'h7FFF_FFF0);
      noise_en = 1; len = 1; loop_en = 0; rate_div = 0; data_ready = 1;
      start = 1'b1; tick; start = 1'b0;
      for (w = 0; w < 20 && !(neg ? n_dv : p_dv); w++) tick;
      got = neg ? n_nd : p_nd;
      e = model_next(0, 1);
      checks++;
      if (!(neg ? n_dv : p_dv)) begin
         failures++; $display("FAIL sat_timeout(neg=%0b): got no valid want valid within 20 cycles", neg);
      end else if (got !== (neg ? 32'h8000_0000 : 32'h7FFF_FFFF)) begin
         failures++; $display("FAIL sat_value(neg=%0b): got %h want %h", neg, got, neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
      end
      checks++; if (nd !== e) begin failures++; $display("FAIL sat_main(neg=%0b): got %h want %h", neg, nd, e); end
      for (int i = 0; i < 5; i++) tick;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_loop_stop;
      test_len_zero;
      test_mid_reset;
      test_noise;
      test_len_clamp;
      test_sat(1'b0);
      test_sat(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noisy_sample_source.md
Name: noisy_sample_source

Overview:
- Stimulus-side counterpart of low_pass_filter: streams a stored 32-bit waveform with controlled pseudo-random noise added, producing the noisy_data stream the filter consumes.
- Replaces file-based feeding with a synthesizable source, so filter characterisation runs on hardware.
- Waveform buffer is loaded through a write port, played out under a valid/ready handshake at a programmable rate, and optionally looped.

Parameters:
- DATA_W, 32, sample width; samples are two's-complement signed.
- DEPTH, 172, waveform buffer entries.
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W >= DEPTH.
- NOISE_BITS, 8, noise magnitude; noise = sign-extended LFSR[NOISE_BITS-1:0].
- LFSR_SEED, 32'h1234_5678, LFSR reset value; 0 is replaced by 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address; writes with wr_addr >= DEPTH are ignored
- wr_data  in  DATA_W  buffer write data
- start  in  1  begin playback; ignored unless in IDLE or DONE
- stop  in  1  abort playback
- len  in  ADDR_W  sample count, sampled on an accepted start; values above DEPTH are clamped to DEPTH
- loop_en  in  1  restart at address 0 after last sample
- noise_en  in  1  1 adds noise, 0 adds zero
- rate_div  in  8  idle cycles inserted after each accepted sample
- noisy_data  out  DATA_W  output sample
- data_valid  out  1  noisy_data is valid
- data_ready  in  1  downstream accepts
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async assert, sync release):
  - noisy_data=0, data_valid=0, busy=0, done=0
  - state=IDLE, rd_addr=0, lfsr=LFSR_SEED
  - buffer contents undefined
- Buffer:
  - Simple dual-port with synchronous read (1-cycle latency).
  - Writes are accepted in every state.
  - A same-address read/write in one cycle returns the old data.
- States:
  - IDLE: on start, latch len/loop. If len==0, go to DONE. Otherwise rd_addr=0 and go to FETCH.
  - FETCH: read at rd_addr is issued; go to CALC.
  - CALC: noisy_data <= sat(q + noise), data_valid <= 1; go to PRESENT.
  - PRESENT: hold noisy_data and data_valid stable until data_valid & data_ready. On that handshake:
    - data_valid <= 0 and lfsr advances.
    - If rd_addr == len-1: with loop, set rd_addr=0 and continue; without loop, go to DONE.
    - Otherwise rd_addr+1.
    - Next state is GAP if rate_div != 0, else FETCH.
  - GAP: count rate_div cycles (rate_div is sampled on entry), then go to FETCH.
  - DONE: done pulses high for the first cycle only. Stays until start, which behaves as in IDLE.
- Throughput: minimum 3 cycles per sample (FETCH, CALC, PRESENT with ready already high), plus rate_div.
- Noise:
  - Uses the current lfsr value; the lfsr advances only on a handshake.
  - The lfsr advances even when noise_en=0, so the sequence is independent of noise_en.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Each step: shift right; if the shifted-out bit is 1, XOR with 32'h8020_0003.
- Arithmetic:
  - Sum is computed at 33 bits signed.
  - Overflow saturates to 32'h7FFF_FFFF or 32'h8000_0000.
- stop:
  - Highest priority in any busy state.
  - Next cycle: IDLE, data_valid=0, no done pulse, lfsr retained.
  - A pending unaccepted sample is discarded.
  - stop and start in the same cycle: stop wins.
- Mid-operation reset: all outputs return to reset values immediately; the buffer is not cleared.
- len, loop_en and rate_div changes during playback have no effect until the next start.
- noise_en is evaluated live in CALC.

Test Plan:
- Load 4 words (0x10, 0x20, 0x30, 0x40); noise_en=0, len=4, rate_div=0, data_ready=1; start.
  -> outputs 0x10, 0x20, 0x30, 0x40, one sample every 3 cycles; done pulses once; busy falls.
- Same setup with data_ready held 0 for 5 cycles on sample 2.
  -> noisy_data stays 0x20 with data_valid high; no sample is lost or duplicated.
- noise_en=1, seed 32'h1234_5678, buffer[0]=0x100.
  -> first sample is 0x178 (noise +0x78); later samples match the Galois reference model.
- Seed 32'h0000_007F, buffer[0]=32'h7FFF_FFF0, noise_en=1.
  -> output 32'h7FFF_FFFF (positive saturation).
- Seed with low byte 0x80, buffer[0]=32'h8000_0010, noise_en=1.
  -> output 32'h8000_0000 (negative saturation).
- loop_en=1, len=3, rate_div=2; stop asserted during the second pass.
  -> sequence wraps to address 0 with 2 idle cycles between samples. After stop: next cycle data_valid=0, busy=0, and done is never pulsed.
